// File: rtl/div_seq.sv
// 32-bit restoring divider: 32 shift/subtract iterations, one sign-fix cycle, one-cycle done pulse.
// Define DIV_SIGNED_EN to build two's-complement division selected by signed_op.
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] din_a,
    input  logic [31:0] din_b,
    input  logic        signed_op,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div0
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] divisor_q, divisor_d;
    logic        bzero_q, bzero_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        div0_q, div0_d;

    logic        accept;
    logic [31:0] mag_a, mag_b;
    logic [31:0] q_fix, r_fix;
    logic [32:0] shifted;
    logic [33:0] trial;

    // A start seen during the done pulse is dropped; the next accept is one cycle later.
    assign accept = (state_q == IDLE) && start && !done_q;

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic qneg_q, qneg_d, rneg_q, rneg_d;

    assign a_neg = signed_op & din_a[31];
    assign b_neg = signed_op & din_b[31];
    assign mag_a = a_neg ? (32'd0 - din_a) : din_a;
    assign mag_b = b_neg ? (32'd0 - din_b) : din_b;
    assign q_fix = qneg_q ? (32'd0 - quo_q) : quo_q;
    assign r_fix = rneg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (accept) begin
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign mag_a = din_a;
    assign mag_b = din_b;
    assign q_fix = quo_q;
    assign r_fix = rem_q[31:0];
`endif

    assign shifted = {rem_q[31:0], quo_q[31]};
    assign trial   = {1'b0, shifted} - {2'b00, divisor_q};

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        bzero_d     = bzero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div0_d      = div0_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d     = 33'd0;
                    quo_d     = mag_a;
                    divisor_d = mag_b;
                    bzero_d   = (din_b == 32'd0);
                    cnt_d     = 6'd32;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // trial[33] is the borrow: restore (keep shifted) when the subtract goes negative.
                if (!trial[33]) begin
                    rem_d = trial[32:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = bzero_q ? 32'hFFFF_FFFF : q_fix;
                remainder_d = r_fix;
                div0_d      = bzero_q;
                state_d     = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            rem_q       <= 33'd0;
            quo_q       <= 32'd0;
            divisor_q   <= 32'd0;
            bzero_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            bzero_q     <= bzero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div0_q      <= div0_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes model results, a negedge monitor pops on done.
// Follows DIV_SIGNED_EN the same way the design does.
module tb_div_seq;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        d0;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] din_a = '0;
    logic [31:0] din_b = '0;
    logic        signed_op = 1'b0;
    logic        busy, done, div0;
    logic [31:0] quotient, remainder;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;
    exp_t exp_q[$];

    div_seq dut (
        .clk(clk), .reset(reset), .start(start), .din_a(din_a), .din_b(din_b),
        .signed_op(signed_op), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div0(div0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        e.cyc = 0;
        e.d0  = (b == 32'd0);
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end
`ifdef DIV_SIGNED_EN
        else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'd0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end
`endif
        else begin
            e.q = a / b;
            e.r = a % b;
        end
        if (s === 1'bx) e.d0 = 1'bx;
        return e;
    endfunction

    // Monitor: one pop per done pulse, with latency and busy-width checks.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_run++;
            if (done) begin
                exp_t e;
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                check("busy_low_in_done", {31'd0, busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div0", {31'd0, div0}, {31'd0, e.d0});
                    check("latency", cyc - e.cyc, 32'd34);
                    check("busy_cycles", busy_run, 32'd34);
                end
                busy_run = 0;
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        bit   ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        check("issue_wait_timeout", {31'd0, ok}, 32'd1);
        start = 1'b1;
        din_a = a;
        din_b = b;
        signed_op = s;
        e = model(a, b, s);
        @(posedge clk);
        #1;
        start = 1'b0;
        e.cyc = cyc;
        exp_q.push_back(e);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_div0", {31'd0, div0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(32'd100, 32'd7, 1'b0);
        wait_idle();
        issue(32'h1234_5678, 32'd0, 1'b0);
        wait_idle();
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        issue(32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_idle();
        issue(32'd5, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        issue(32'hFFFF_FFF9, 32'd0, 1'b1);
        wait_idle();

        // A second start mid-operation must be ignored.
        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        din_a = 32'd5;
        din_b = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-operation aborts without a done pulse.
        issue(32'hDEAD_BEEF, 32'd3, 1'b0);
        wait_idle();
        issue(32'd1000, 32'd9, 1'b0);
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_quotient", quotient, 32'd0);
        check("mid_rst_remainder", remainder, 32'd0);
        check("mid_rst_div0", {31'd0, div0}, 32'd0);
        exp_q.delete();
        busy_run = 0;
        prev_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        issue(32'd1000, 32'd9, 1'b0);
        wait_idle();

        for (int n = 0; n < 20; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 15);
                1: b = $urandom & 32'h0000_FFFF;
                2: b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            issue(a, b, 1'($urandom_range(0, 1)));
            wait_idle();
        end

        check("queue_empty_at_end", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
